// File: rtl/wb2stream_host.sv
// rtl/wb2stream_host.sv - host initiator: local requests to 5-byte command frames, 4-byte responses
module wb2stream_host #(
   parameter int RD_WAIT = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [3:0]  req_sel,
   input  logic [15:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_last,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        busy
);
   localparam int TW = $clog2(TIMEOUT);
   localparam int GW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_TX   = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;
   localparam logic [1:0] S_RX   = 2'd3;

   localparam logic [1:0] OP_SYNC  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;

   localparam logic [3:0] C_SYNC = 4'h0;
   localparam logic [3:0] C_REG  = 4'h1;
   localparam logic [3:0] C_DSET = 4'h2;
   localparam logic [3:0] C_DGET = 4'h3;
   localparam logic [3:0] C_AUX  = 4'h4;

   localparam logic [31:0] SYNC_WORD = 32'hCAFEBABE;

   logic [1:0]    state_q;
   logic [1:0]    op_q;
   logic [3:0]    sel_q;
   logic [15:0]   addr_q;
   logic [31:0]   wdata_q;
   logic          frm_q;
   logic [2:0]    byte_q;
   logic [GW-1:0] gap_q;
   logic [TW-1:0] tmo_q;
   logic [1:0]    rx_cnt_q;
   logic [31:0]   shift_q;
   logic          err_q;

   logic [3:0]    code;
   logic [31:0]   arg;
   logic [7:0]    tx_byte;
   logic [31:0]   rx_word;
   logic          rx_mism;
   logic          sync_bad;

   // Frame contents follow from the latched op and which of its (at most two) frames is active.
   always_comb begin
      code = C_SYNC;
      arg  = 32'h0;
      case (op_q)
         OP_SYNC: code = C_SYNC;
         OP_WRITE: begin
            if (!frm_q) begin
               code = C_DSET;
               arg  = wdata_q;
            end else begin
               code = C_REG;
               arg  = {11'b0, 1'b0, sel_q, addr_q};
            end
         end
         OP_READ: begin
            if (!frm_q) begin
               code = C_REG;
               arg  = {11'b0, 1'b1, sel_q, addr_q};
            end else begin
               code = C_DGET;
            end
         end
         default: begin
            code = C_AUX;
            arg  = wdata_q;
         end
      endcase
   end

   always_comb begin
      tx_byte = 8'h00;
      case (byte_q)
         3'd0:    tx_byte = {code, 4'h0};
         3'd1:    tx_byte = arg[31:24];
         3'd2:    tx_byte = arg[23:16];
         3'd3:    tx_byte = arg[15:8];
         default: tx_byte = arg[7:0];
      endcase
   end

   always_comb begin
      rx_word  = {shift_q[23:0], rx_data};
      rx_mism  = rx_last ^ (rx_cnt_q == 2'd3);
      sync_bad = (op_q == OP_SYNC) && (rx_word != SYNC_WORD);
   end

   assign tx_valid  = (state_q == S_TX);
   assign tx_data   = (state_q == S_TX) ? tx_byte : 8'h00;
   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign rx_ready  = 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= 2'd0;
         sel_q     <= 4'h0;
         addr_q    <= 16'h0;
         wdata_q   <= 32'h0;
         frm_q     <= 1'b0;
         byte_q    <= 3'd0;
         gap_q     <= '0;
         tmo_q     <= '0;
         rx_cnt_q  <= 2'd0;
         shift_q   <= 32'h0;
         err_q     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  sel_q   <= req_sel;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  frm_q   <= 1'b0;
                  byte_q  <= 3'd0;
                  state_q <= S_TX;
               end
            end
            S_TX: begin
               if (tx_ready) begin
                  if (byte_q != 3'd4) begin
                     byte_q <= byte_q + 3'd1;
                  end else begin
                     byte_q <= 3'd0;
                     if (op_q == OP_SYNC || (op_q == OP_READ && frm_q)) begin
                        state_q  <= S_RX;
                        shift_q  <= 32'h0;
                        tmo_q    <= '0;
                        rx_cnt_q <= 2'd0;
                        err_q    <= 1'b0;
                     end else if (op_q == OP_READ) begin
                        frm_q <= 1'b1;
                        gap_q <= '0;
                        if (RD_WAIT != 0) state_q <= S_GAP;
                     end else if (op_q == OP_WRITE && !frm_q) begin
                        frm_q <= 1'b1;
                     end else begin
                        state_q   <= S_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= 32'h0;
                        rsp_err   <= 1'b0;
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_q == GW'(RD_WAIT - 1)) state_q <= S_TX;
               else gap_q <= gap_q + 1'b1;
            end
            S_RX: begin
               if (rx_valid) begin
                  shift_q  <= rx_word;
                  tmo_q    <= '0;
                  rx_cnt_q <= rx_cnt_q + 2'd1;
                  if (rx_cnt_q == 2'd3) begin
                     state_q   <= S_IDLE;
                     rsp_valid <= 1'b1;
                     rsp_data  <= rx_word;
                     rsp_err   <= err_q | rx_mism | sync_bad;
                  end else begin
                     err_q <= err_q | rx_mism;
                  end
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  // Silent link: report whatever bytes made it in.
                  state_q   <= S_IDLE;
                  rsp_valid <= 1'b1;
                  rsp_data  <= shift_q;
                  rsp_err   <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wb2stream_host.sv
// tb/tb_wb2stream_host.sv - bench for wb2stream_host: vector table, hand sequences, random ops vs model
module tb_wb2stream_host;
   localparam int RD_WAIT = 16;
   localparam int TIMEOUT = 1024;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [3:0]  req_sel;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_last;
   logic        rx_valid;
   logic        rx_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   wb2stream_host #(.RD_WAIT(RD_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sel(req_sel),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_last(rx_last), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  got_tx[$];
   int          got_txt[$];
   int          got_rsp_t;
   int          got_last_ev;
   logic [31:0] got_data;
   logic        got_err;
   logic        got_rdy;
   logic        got_busy;

   logic [7:0]  exp_tx[$];
   logic [31:0] exp_data;
   logic        exp_err;

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  sel;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          mode;
      logic [31:0] rword;
      logic [3:0]  rlast;
      int          nrx;
      logic [79:0] tx;
      int          ntx;
      logic [31:0] data;
      logic        err;
      int          rsp_t;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void push_frame(input logic [3:0] code, input logic [31:0] arg);
      exp_tx.push_back({code, 4'h0});
      for (int i = 3; i >= 0; i--) exp_tx.push_back(arg[8*i +: 8]);
   endfunction

   // Reference: frames and response derived directly from the protocol rules.
   function automatic void model(input logic [1:0] op, input logic [3:0] sel, input logic [15:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rword,
                                 input logic [3:0] rlast, input int nrx);
      exp_tx.delete();
      case (op)
         2'd0: push_frame(4'h0, 32'h0);
         2'd1: begin
            push_frame(4'h2, wdata);
            push_frame(4'h1, {11'b0, 1'b0, sel, addr});
         end
         2'd2: begin
            push_frame(4'h1, {11'b0, 1'b1, sel, addr});
            push_frame(4'h3, 32'h0);
         end
         default: push_frame(4'h4, wdata);
      endcase
      if (op == 2'd1 || op == 2'd3) begin
         exp_data = 32'h0;
         exp_err  = 1'b0;
      end else if (nrx < 4) begin
         exp_data = rword >> (8 * (4 - nrx));
         exp_err  = 1'b1;
      end else begin
         exp_data = rword;
         exp_err  = (rlast != 4'b1000) || (op == 2'd0 && rword != 32'hCAFEBABE);
      end
   endfunction

   // Caller is 1 time unit after a rising edge; returns the same way in the rsp_valid cycle.
   task automatic run_op(input logic [1:0] op, input logic [3:0] sel, input logic [15:0] addr,
                         input logic [31:0] wdata, input int mode, input logic [31:0] rword,
                         input logic [3:0] rlast, input int nrx, input int gap_max);
      int t;
      int ntx;
      int tx_done_t;
      int rxi;
      int gap;
      bit stall;
      bit done;
      logic [7:0] sdata;
      ntx = (op == 2'd1 || op == 2'd2) ? 10 : 5;
      got_tx.delete();
      got_txt.delete();
      got_rsp_t = -1;
      got_last_ev = -1;
      tx_done_t = -1;
      rxi = 0;
      gap = 0;
      stall = 0;
      done = 0;
      sdata = 8'h00;
      chk("req_ready_before", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_sel   = sel;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_sel   = 4'($urandom);
      req_addr  = 16'($urandom);
      req_wdata = $urandom;
      t = 1;
      while (!done && t < 4000) begin
         rx_valid = 1'b0;
         rx_last  = 1'b0;
         rx_data  = 8'($urandom);
         if (rsp_valid) begin
            done      = 1;
            got_rsp_t = t;
            got_data  = rsp_data;
            got_err   = rsp_err;
            got_rdy   = req_ready;
            got_busy  = busy;
            tx_ready  = 1'b0;
         end else begin
            if (stall) chk("tx_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, sdata});
            case (mode)
               0:       tx_ready = 1'b1;
               1:       tx_ready = ((t % 2) == 1);
               default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (tx_valid && tx_ready) begin
               got_tx.push_back(tx_data);
               got_txt.push_back(t);
               if (got_tx.size() == ntx) begin
                  tx_done_t   = t;
                  got_last_ev = t;
               end
            end
            stall = tx_valid && !tx_ready;
            sdata = tx_data;
            if (tx_done_t >= 0 && t > tx_done_t && rxi < nrx) begin
               if (gap > 0) gap--;
               else begin
                  rx_valid    = 1'b1;
                  rx_data     = rword[31 - 8*rxi -: 8];
                  rx_last     = rlast[rxi];
                  rxi++;
                  got_last_ev = t;
                  gap         = $urandom_range(0, gap_max);
               end
            end
            @(posedge clk); #1;
            t++;
         end
      end
      rx_valid = 1'b0;
      rx_last  = 1'b0;
      if (!done) chk("rsp_seen", 32'd0, 32'd1);
   endtask

   task automatic check_result(input logic [1:0] op, input int mode, input int nrx, input int ersp);
      int bad;
      int et;
      chk("tx_count", 32'(got_tx.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
         chk("tx_byte", {24'h0, got_tx[i]}, {24'h0, exp_tx[i]});
      if (mode == 0) begin
         bad = 0;
         for (int i = 0; i < got_txt.size(); i++) begin
            et = i + 1 + ((op == 2'd2 && i >= 5) ? RD_WAIT : 0);
            if (got_txt[i] != et) bad++;
         end
         chk("tx_timing", 32'(bad), 32'd0);
      end
      if (op == 2'd2 && got_txt.size() == 10)
         chk("gap_len", 32'((got_txt[5] - got_txt[4] - 1) >= RD_WAIT), 32'd1);
      et = got_last_ev + 1 + (((op == 2'd0 || op == 2'd2) && nrx < 4) ? TIMEOUT : 0);
      chk("rsp_time", 32'(got_rsp_t), 32'(et));
      if (ersp >= 0) chk("rsp_cycle", 32'(got_rsp_t), 32'(ersp));
      chk("rsp_data", got_data, exp_data);
      chk("rsp_err", 32'(got_err), 32'(exp_err));
      chk("ready_with_rsp", {30'h0, got_rdy, got_busy}, 32'b10);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] rw;
      logic [3:0]  rl;
      int          md;
      int          bad;

      tbl[0] = '{2'd1, 4'd2, 16'h1234, 32'hDEADBEEF, 0, 32'h0, 4'h0, 0,
                 80'h20DEADBEEF1000021234, 10, 32'h0, 1'b0, 11};
      tbl[1] = '{2'd2, 4'd0, 16'h0008, 32'h0, 1, 32'h12345678, 4'b1000, 4,
                 80'h1000100008_3000000000, 10, 32'h12345678, 1'b0, -1};
      tbl[2] = '{2'd0, 4'd0, 16'h0, 32'h0, 0, 32'hCAFEBABE, 4'b1000, 4,
                 80'h0000000000_0000000000, 5, 32'hCAFEBABE, 1'b0, -1};
      tbl[3] = '{2'd0, 4'd0, 16'h0, 32'h0, 0, 32'hCAFEBABF, 4'b1000, 4,
                 80'h0000000000_0000000000, 5, 32'hCAFEBABF, 1'b1, -1};
      tbl[4] = '{2'd0, 4'd0, 16'h0, 32'h0, 2, 32'hCAFEBABE, 4'b0010, 4,
                 80'h0000000000_0000000000, 5, 32'hCAFEBABE, 1'b1, -1};
      tbl[5] = '{2'd0, 4'd0, 16'h0, 32'h0, 0, 32'hCAFE0000, 4'b0000, 2,
                 80'h0000000000_0000000000, 5, 32'h0000CAFE, 1'b1, -1};
      tbl[6] = '{2'd3, 4'd0, 16'h0, 32'h00031800, 0, 32'h0, 4'h0, 0,
                 80'h4000031800_0000000000, 5, 32'h0, 1'b0, 6};
      tbl[7] = '{2'd2, 4'd5, 16'hBEEF, 32'h0, 2, 32'h0BADF00D, 4'b1001, 4,
                 80'h100015BEEF_3000000000, 10, 32'h0BADF00D, 1'b1, -1};

      rst_n = 1'b0; req_valid = 1'b1; req_op = 2'd1; req_sel = 4'h0; req_addr = 16'h0;
      req_wdata = 32'h0; tx_ready = 1'b1; rx_valid = 1'b0; rx_last = 1'b0; rx_data = 8'h0;

      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("reset_tx_valid", 32'(tx_valid), 32'd0);
         chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      req_valid = 1'b0;
      rst_n = 1'b1;
      chk("post_reset", {req_ready, busy, rsp_err, tx_valid, tx_data, 20'h0}, 32'h8000_0000);
      chk("post_reset_rsp_data", rsp_data, 32'h0);

      // Reset in the middle of a write frame.
      req_valid = 1'b1; req_op = 2'd1; req_sel = 4'd1; req_addr = 16'h5555; req_wdata = 32'h11223344;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         chk("midwr_tx_valid", 32'(tx_valid), 32'd1);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midwr_reset", {29'h0, tx_valid, busy, req_ready}, 32'd1);
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         rx_valid = 1'b1; rx_data = 8'($urandom); rx_last = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (busy || rsp_valid || tx_valid) bad++;
      end
      rx_valid = 1'b0; rx_last = 1'b0;
      chk("stray_rx_ignored", 32'(bad), 32'd0);

      for (int k = 0; k < 8; k++) begin
         run_op(tbl[k].op, tbl[k].sel, tbl[k].addr, tbl[k].wdata, tbl[k].mode,
                tbl[k].rword, tbl[k].rlast, tbl[k].nrx, 2);
         exp_tx.delete();
         for (int i = 0; i < tbl[k].ntx; i++) exp_tx.push_back(tbl[k].tx[79 - 8*i -: 8]);
         exp_data = tbl[k].data;
         exp_err  = tbl[k].err;
         check_result(tbl[k].op, tbl[k].mode, tbl[k].nrx, tbl[k].rsp_t);
      end

      for (int k = 0; k < 40; k++) begin
         op = 2'($urandom_range(0, 3));
         md = $urandom_range(0, 2);
         rw = (op == 2'd0 && $urandom_range(0, 1) == 1) ? 32'hCAFEBABE : $urandom;
         rl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1000;
         req_sel = 4'($urandom); req_addr = 16'($urandom); req_wdata = $urandom;
         model(op, req_sel, req_addr, req_wdata, rw, rl, 4);
         run_op(op, req_sel, req_addr, req_wdata, md, rw, rl, 4, 3);
         check_result(op, md, 4, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
